mux4_rr_arbiter: RTL



---
 rtl/mux4_rr_arbiter_pkg.sv | 24 ++
 rtl/mux4_rr_arbiter_rr_pick_4.sv | 34 +++
 rtl/mux4_rr_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter:
// FSM encoding, default hold limit and a one-hot decode helper.
package mux4_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int MAX_HOLD_DEFAULT = 8;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    case (idx)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      2'd3:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick_4.sv
// Combinational round-robin picker: the first requester after 'last'
// (wrapping mod 4) wins, so the previous owner is scanned last.
module rr_pick_4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any_req
);

  logic [1:0] w_start;
  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  logic [1:0] w_off;

  assign w_start = last + 2'd1;
  assign w_dbl   = {req, req};
  assign w_rot   = w_dbl[{1'b0, w_start} +: 4];
  assign any_req = |req;
  assign pick    = w_start + w_off;

  // priority encode the rotated request vector
  always_comb begin
    if (w_rot[0]) begin
      w_off = 2'd0;
    end else if (w_rot[1]) begin
      w_off = 2'd1;
    end else if (w_rot[2]) begin
      w_off = 2'd2;
    end else begin
      w_off = 2'd3;
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux path with a bounded hold time;
// all outputs are registered and a timeout revocation pulses preempt.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_gnt,     w_gnt_nxt;
  logic [1:0]       r_sel,     w_sel_nxt;
  logic [1:0]       r_last,    w_last_nxt;
  logic [CNT_W-1:0] r_hold,    w_hold_nxt;
  logic             r_busy,    r_preempt, w_preempt_nxt;
  logic [1:0]       w_pick;
  logic             w_any_req;
  logic             w_others;

  rr_pick_4 u_pick (
    .req     (req),
    .last    (r_last),
    .pick    (w_pick),
    .any_req (w_any_req)
  );

  assign w_others = |(req & ~onehot4(r_sel));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state and next-output decision
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_last_nxt    = r_last;
    w_hold_nxt    = r_hold;
    w_preempt_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = onehot4(w_pick);
          w_sel_nxt   = w_pick;
          w_last_nxt  = w_pick;
          w_hold_nxt  = '0;
        end else begin
          w_gnt_nxt  = 4'b0000;
          w_hold_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (!req[r_sel]) begin
          w_hold_nxt = '0;
          if (w_any_req) begin
            w_gnt_nxt  = onehot4(w_pick);
            w_sel_nxt  = w_pick;
            w_last_nxt = w_pick;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 4'b0000;
          end
        end else if (r_hold < HOLD_LAST) begin
          w_hold_nxt = r_hold + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          // timeout: previous owner sits last in the scan, so pick is someone else
          w_hold_nxt = '0;
          if (w_others) begin
            w_gnt_nxt     = onehot4(w_pick);
            w_sel_nxt     = w_pick;
            w_last_nxt    = w_pick;
            w_preempt_nxt = 1'b1;
          end else begin
            w_gnt_nxt = r_gnt;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_sel_nxt   = 2'd0;
        w_last_nxt  = 2'd3;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt     <= 4'b0000;
      r_sel     <= 2'd0;
      r_last    <= 2'd3;
      r_hold    <= '0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_last    <= w_last_nxt;
      r_hold    <= w_hold_nxt;
      r_busy    <= |w_gnt_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule
